// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with per-requester packet lock feeding a UART byte serializer.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1) between the data bits and the stop bit.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CLK_DIV = 104,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW = $clog2(CLK_DIV)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_lock,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 uart_tx,
    output logic                 busy,
    output logic [GW-1:0]        grant_id
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg;
    logic [2:0]     bit_reg;
    logic [7:0]     data_reg;
    logic [GW-1:0]  ptr_reg, owner_reg, grant_id_reg;
    logic           locked_reg;

    logic           tick, lock_hold, win_found, accept;
    logic [GW-1:0]  win_idx, rr_cand;
    logic [7:0]     win_byte;

    assign tick = (cnt_reg == CW'(CLK_DIV - 1));

    // A held lock narrows eligibility to the owner; otherwise the first valid at or above ptr wins.
    always_comb begin
        lock_hold = locked_reg & req_lock[owner_reg];
        win_found = 1'b0;
        win_idx   = '0;
        rr_cand   = '0;
        if (lock_hold) begin
            win_found = req_valid[owner_reg];
            win_idx   = owner_reg;
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                rr_cand = GW'((int'(ptr_reg) + k) % NUM_REQ);
                if (req_valid[rr_cand]) begin
                    win_found = 1'b1;
                    win_idx   = rr_cand;
                end
            end
        end
        accept = (state_reg == S_IDLE) && win_found && !rst;
    end

    always_comb begin
        win_byte = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx == GW'(k)) win_byte = req_data[8*k +: 8];
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = accept && (win_idx == GW'(gi));
        end
    endgenerate

    // State register, baud counter and bit index
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_IDLE || state_next != state_reg || tick)
                cnt_reg <= '0;
            else
                cnt_reg <= cnt_reg + 1'b1;
            if (state_reg == S_DATA && tick)
                bit_reg <= bit_reg + 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept) state_next = S_START;
            S_START: if (tick) state_next = S_DATA;
`ifdef UART_TX_PARITY_EN
            S_DATA:   if (tick && bit_reg == 3'd7) state_next = S_PARITY;
            S_PARITY: if (tick) state_next = S_STOP;
`else
            S_DATA:  if (tick && bit_reg == 3'd7) state_next = S_STOP;
`endif
            S_STOP:  if (tick) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        uart_tx = 1'b1;
        case (state_reg)
            S_START:  uart_tx = 1'b0;
            S_DATA:   uart_tx = data_reg[bit_reg];
`ifdef UART_TX_PARITY_EN
            S_PARITY: uart_tx = ^data_reg;
`endif
            default:  uart_tx = 1'b1;
        endcase
        busy = (state_reg != S_IDLE);
    end

    // Grant bookkeeping: lock keeps ptr frozen so arbitration resumes where it left off.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg     <= '0;
            grant_id_reg <= '0;
            ptr_reg      <= '0;
            owner_reg    <= '0;
            locked_reg   <= 1'b0;
        end else if (accept) begin
            data_reg     <= win_byte;
            grant_id_reg <= win_idx;
            if (req_lock[win_idx]) begin
                locked_reg <= 1'b1;
                owner_reg  <= win_idx;
            end else begin
                locked_reg <= 1'b0;
                ptr_reg    <= (win_idx == GW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
        end else if (state_reg == S_IDLE && !lock_hold) begin
            locked_reg <= 1'b0;
        end
    end

    assign grant_id = grant_id_reg;

endmodule
